pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Central game-flow sequencer for the Pong datapath, running on `CLOCK_25`. It replaces the ad-hoc pause/reset latch with a single state machine. It debounces the two push-buttons, owns both score counters, and tells the ball/paddle datapath when to run, when to serve and when to reset. It also presents the winner to the win-screen and animation logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: number of stable `CLOCK_25` cycles (10 ms) a synchronized key level must hold before it is accepted.
- `WIN_POINTS`, default 7, range 1..7: score value at which a player wins.
- `SERVE_DELAY`, default 60, range 1..255: `frame_tick` pulses spent in POINT before the next serve.
- `WIN_HOLD`, default 180, range 1..255: `frame_tick` pulses spent in WIN before the automatic return to IDLE.

Ports:
- `CLOCK_25`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `key0`, in, 1: pause/start button, active-low, asynchronous.
- `key1`, in, 1: game-reset button, active-low, asynchronous.
- `frame_tick`, in, 1: one-cycle pulse per game step (ball clock edge), synchronous to `CLOCK_25`.
- `goal_p1`, in, 1: one-cycle pulse; player 1 scored (ball passed paddle 2).
- `goal_p2`, in, 1: one-cycle pulse; player 2 scored.
- `run`, out, 1: datapath enable; the ball and paddles move only while this is high.
- `serve`, out, 1: one-cycle pulse; datapath re-centres the ball toward `serve_side`.
- `serve_side`, out, 1: 0 = serve toward player 1, 1 = serve toward player 2.
- `game_reset`, out, 1: one-cycle pulse; datapath restores initial positions.
- `score_1`, out, 3: player 1 score.
- `score_2`, out, 3: player 2 score.
- `winner`, out, 2: 00 = none, 01 = player 1, 10 = player 2.
- `state`, out, 3: IDLE=0, PLAY=1, PAUSE=2, POINT=3, WIN=4.

## Operation
Key conditioning:
- Each key passes through a 2-FF synchronizer.
- A debounce counter reloads on any change of the synchronized level. The debounced level updates once the level has been stable for `DEBOUNCE_CYCLES` cycles.
- A press event `k0_ev`/`k1_ev` is a one-cycle pulse on a debounced 1→0 edge. Releases generate no event.

State machine (a `k1_ev` overrides everything, in every state):
- `k1_ev` in any state → IDLE. Scores clear to 0, `winner` clears to 00, `serve_side` clears to 0, and `game_reset` pulses.
- IDLE: `k0_ev` → PLAY. Goals are ignored.
- PLAY, on `goal_p1`: `score_1` increments.
  - If the new value equals `WIN_POINTS` → WIN, with `winner`=01.
  - Otherwise → POINT, with `serve_side`=1 (the loser serves/receives).
- PLAY, on `goal_p2`: mirror of the above, with `winner`=10 and `serve_side`=0.
- PLAY, simultaneous `goal_p1` and `goal_p2`: `goal_p1` is taken and `goal_p2` is dropped.
- PLAY, goal together with `k0_ev`: the goal is taken and the key event is discarded.
- PLAY, `k0_ev` alone → PAUSE.
- PAUSE: `k0_ev` → PLAY. Goals are ignored.
- POINT, on entry: the delay counter loads `SERVE_DELAY`.
- POINT: each `frame_tick` decrements the counter. On the tick that takes it to 0 → PLAY, with `serve` pulsing in the same cycle `run` rises. `k0_ev` and goals are ignored.
- WIN, on entry: the counter loads `WIN_HOLD`.
- WIN, counter reaches 0 or `k0_ev` occurs → IDLE. Scores clear, `winner` clears, and `game_reset` pulses. Goals are ignored.

Outputs:
- `run` = (state == PLAY), registered.
- Scores saturate by construction: WIN is always entered at `WIN_POINTS`, so they never wrap.

## Timing
Reset values:
- `state`=IDLE, `run`=0, `serve`=0, `serve_side`=0, `game_reset`=0, `score_1`=0, `score_2`=0, `winner`=00.
- Debounced levels = 1 (released); all counters = 0.

Latency:
- Key edge to event: 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- Event/goal pulse in cycle N: `state`, `run`, scores and pulses update at the edge ending cycle N (visible in N+1).
- `serve` and `game_reset` are exactly 1 cycle wide and never asserted together.

Boundary conditions:
- `frame_tick` arriving in the same cycle as POINT/WIN entry is not counted.
- Reset asserted mid-POINT or mid-WIN aborts immediately to the reset values.
- Key glitches shorter than `DEBOUNCE_CYCLES` produce no event.

## Test plan
Run the bench with `DEBOUNCE_CYCLES`=4, `WIN_POINTS`=3, `SERVE_DELAY`=2, `WIN_HOLD`=3.
- **Reset/start:** release `reset`, then press `key0` for 10 cycles → `state` goes 0→1 and `run`=1 exactly 2+4+1+1 cycles after the falling edge; `game_reset`=0 throughout.
- **Debounce:** `key0` low for 3 cycles in PLAY → no state change. Held for 10 cycles → PAUSE and `run`=0. Second press → PLAY.
- **Point/serve:** in PLAY, pulse `goal_p2` → `score_2`=1, `state`=3, `serve_side`=0, `run`=0. After 2 `frame_tick` → `serve` pulses once, `state`=1, `run`=1.
- **Win/auto-return:** three `goal_p1` pulses, with serves in between → `score_1`=3, `winner`=01, `state`=4. After 3 ticks → `state`=0, scores 0, `winner`=00, single `game_reset` pulse.
- **Priority:** `goal_p1` and `goal_p2` in the same cycle → only `score_1` increments. Goal coinciding with `k0_ev` → POINT, not PAUSE.
- **Override:** `key1` press during POINT with `score_2`=2 → IDLE, scores 0, one `game_reset` pulse, no `serve` pulse.

Source files
------------

// File: rtl/pong_match_controller.sv
// ---------------------------------------------------------------------------
// pong_match_controller
//
// Game-flow sequencer for the Pong datapath. It conditions the two push-
// buttons, keeps both score counters, and tells the ball/paddle datapath when
// to run, when to serve and when to restore its initial positions.
//
// Ports
//   CLOCK_25    in   sole clock
//   reset       in   asynchronous, active-high reset
//   key0        in   pause/start button, active-low, asynchronous
//   key1        in   game-reset button, active-low, asynchronous
//   frame_tick  in   one-cycle pulse per game step
//   goal_p1     in   one-cycle pulse, player 1 scored
//   goal_p2     in   one-cycle pulse, player 2 scored
//   run         out  datapath enable (high only in PLAY)
//   serve       out  one-cycle pulse, re-centre ball toward serve_side
//   serve_side  out  0 = toward player 1, 1 = toward player 2
//   game_reset  out  one-cycle pulse, datapath restores initial positions
//   score_1     out  player 1 score
//   score_2     out  player 2 score
//   winner      out  00 none, 01 player 1, 10 player 2
//   state       out  IDLE=0 PLAY=1 PAUSE=2 POINT=3 WIN=4
// ---------------------------------------------------------------------------
module pong_match_controller #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int WIN_POINTS      = 7,
   parameter int SERVE_DELAY     = 60,
   parameter int WIN_HOLD        = 180
) (
   input  logic       CLOCK_25,
   input  logic       reset,
   input  logic       key0,
   input  logic       key1,
   input  logic       frame_tick,
   input  logic       goal_p1,
   input  logic       goal_p2,
   output logic       run,
   output logic       serve,
   output logic       serve_side,
   output logic       game_reset,
   output logic [2:0] score_1,
   output logic [2:0] score_2,
   output logic [1:0] winner,
   output logic [2:0] state
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       WIN_LVL   = 3'(WIN_POINTS);
   localparam logic [7:0]       SERVE_LD  = 8'(SERVE_DELAY);
   localparam logic [7:0]       HOLD_LD   = 8'(WIN_HOLD);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      PAUSE = 3'd2,
      POINT = 3'd3,
      WIN   = 3'd4
   } state_t;

   state_t           st;
   logic [1:0]       key_p0, key_p1;      // bit 0 = key0, bit 1 = key1
   logic [1:0]       key_db, key_db_d;    // debounced level and its delayed copy
   logic [1:0]       key_ev;              // one-cycle press events
   logic [CNT_W-1:0] db_cnt [2];
   logic [7:0]       delay_cnt;
   logic             k0_ev, k1_ev;
   logic [2:0]       score_1_inc, score_2_inc;

   assign k0_ev       = key_ev[0];
   assign k1_ev       = key_ev[1];
   assign score_1_inc = score_1 + 3'd1;
   assign score_2_inc = score_2 + 3'd1;
   assign state       = st;

   // Key conditioning: 2-FF sync (_p0/_p1), then debounce, then edge detect.
   // The counter only runs while the synchronized level differs from the
   // accepted level, so any bounce back clears it and restarts the wait.
   always_ff @(posedge CLOCK_25 or posedge reset) begin
      if (reset) begin
         key_p0    <= 2'b11;
         key_p1    <= 2'b11;
         key_db    <= 2'b11;
         key_db_d  <= 2'b11;
         key_ev    <= 2'b00;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         key_p0   <= {key1, key0};
         key_p1   <= key_p0;
         key_db_d <= key_db;
         key_ev   <= key_db_d & ~key_db;   // press = debounced 1->0
         for (int i = 0; i < 2; i++) begin
            if (key_p1[i] == key_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               key_db[i] <= key_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Match state machine. A key1 press wins over everything else; in PLAY a
   // goal wins over key0, and goal_p1 wins over goal_p2.
   always_ff @(posedge CLOCK_25 or posedge reset) begin
      if (reset) begin
         st         <= IDLE;
         run        <= 1'b0;
         serve      <= 1'b0;
         serve_side <= 1'b0;
         game_reset <= 1'b0;
         score_1    <= 3'd0;
         score_2    <= 3'd0;
         winner     <= 2'b00;
         delay_cnt  <= 8'd0;
      end else begin
         serve      <= 1'b0;
         game_reset <= 1'b0;
         if (k1_ev) begin
            st         <= IDLE;
            run        <= 1'b0;
            score_1    <= 3'd0;
            score_2    <= 3'd0;
            winner     <= 2'b00;
            serve_side <= 1'b0;
            game_reset <= 1'b1;
            delay_cnt  <= 8'd0;
         end else begin
            case (st)
               IDLE: begin
                  if (k0_ev) begin
                     st  <= PLAY;
                     run <= 1'b1;
                  end
               end
               PLAY: begin
                  if (goal_p1) begin
                     score_1 <= score_1_inc;
                     run     <= 1'b0;
                     if (score_1_inc == WIN_LVL) begin
                        st        <= WIN;
                        winner    <= 2'b01;
                        delay_cnt <= HOLD_LD;
                     end else begin
                        st         <= POINT;
                        serve_side <= 1'b1;
                        delay_cnt  <= SERVE_LD;
                     end
                  end else if (goal_p2) begin
                     score_2 <= score_2_inc;
                     run     <= 1'b0;
                     if (score_2_inc == WIN_LVL) begin
                        st        <= WIN;
                        winner    <= 2'b10;
                        delay_cnt <= HOLD_LD;
                     end else begin
                        st         <= POINT;
                        serve_side <= 1'b0;
                        delay_cnt  <= SERVE_LD;
                     end
                  end else if (k0_ev) begin
                     st  <= PAUSE;
                     run <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (k0_ev) begin
                     st  <= PLAY;
                     run <= 1'b1;
                  end
               end
               POINT: begin
                  if (frame_tick) begin
                     if (delay_cnt == 8'd1) begin
                        st    <= PLAY;
                        run   <= 1'b1;
                        serve <= 1'b1;   // rises together with run
                     end
                     delay_cnt <= delay_cnt - 8'd1;
                  end
               end
               WIN: begin
                  if (k0_ev || (frame_tick && delay_cnt == 8'd1)) begin
                     st         <= IDLE;
                     score_1    <= 3'd0;
                     score_2    <= 3'd0;
                     winner     <= 2'b00;
                     game_reset <= 1'b1;
                     delay_cnt  <= 8'd0;
                  end else if (frame_tick) begin
                     delay_cnt <= delay_cnt - 8'd1;
                  end
               end
               default: begin
                  st  <= IDLE;
                  run <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_match_controller.sv
// ---------------------------------------------------------------------------
// tb_pong_match_controller
//
// Directed bench for pong_match_controller with DEBOUNCE_CYCLES=4,
// WIN_POINTS=3, SERVE_DELAY=2, WIN_HOLD=3. A vector table covers the steady
// game flow; hand-written sequences cover start latency, goal/key collision,
// key1 override during POINT and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pong_match_controller;

   logic       CLOCK_25;
   logic       reset;
   logic       key0, key1, frame_tick, goal_p1, goal_p2;
   logic       run, serve, serve_side, game_reset;
   logic [2:0] score_1, score_2, state;
   logic [1:0] winner;

   int n_chk  = 0;
   int n_pass = 0;
   int n_serve = 0;
   int n_gr    = 0;
   int n_both  = 0;

   pong_match_controller #(
      .DEBOUNCE_CYCLES(4),
      .WIN_POINTS     (3),
      .SERVE_DELAY    (2),
      .WIN_HOLD       (3)
   ) dut (
      .CLOCK_25  (CLOCK_25),
      .reset     (reset),
      .key0      (key0),
      .key1      (key1),
      .frame_tick(frame_tick),
      .goal_p1   (goal_p1),
      .goal_p2   (goal_p2),
      .run       (run),
      .serve     (serve),
      .serve_side(serve_side),
      .game_reset(game_reset),
      .score_1   (score_1),
      .score_2   (score_2),
      .winner    (winner),
      .state     (state)
   );

   initial CLOCK_25 = 1'b0;
   always #5 CLOCK_25 = ~CLOCK_25;

   // Pulse counters, sampled mid-cycle.
   always @(negedge CLOCK_25) begin
      if (serve)               n_serve++;
      if (game_reset)          n_gr++;
      if (serve && game_reset) n_both++;
   end

   typedef struct packed {
      logic       p0, p1, tk, g1, g2;   // p0/p1: 1 = button pressed
      int         cyc;
      logic [2:0] st;
      logic       run;
      logic [2:0] s1, s2;
      logic [1:0] win;
      logic       side;
      int         ns, ng;               // cumulative serve / game_reset pulses
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   task automatic tick();
      @(posedge CLOCK_25);
      #1;
   endtask

   task automatic set_idle();
      key0 = 1'b1; key1 = 1'b1; frame_tick = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input int st, input int rn, input int s1,
                          input int s2, input int wn, input int sd);
      chk({tag, " state"},      int'(state),      st);
      chk({tag, " run"},        int'(run),        rn);
      chk({tag, " score_1"},    int'(score_1),    s1);
      chk({tag, " score_2"},    int'(score_2),    s2);
      chk({tag, " winner"},     int'(winner),     wn);
      chk({tag, " serve_side"}, int'(serve_side), sd);
   endtask

   int base_s, base_g;

   initial begin
      //          p0 p1 tk g1 g2 cyc  st run s1 s2 win side ns ng
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3, 3'd1,1'b1,3'd0,3'd0,2'd0,1'b0, 0, 0}; // glitch
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,10, 3'd2,1'b0,3'd0,3'd0,2'd0,1'b0, 0, 0}; // pause
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1, 3'd2,1'b0,3'd0,3'd0,2'd0,1'b0, 0, 0}; // goal ignored
      tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,10, 3'd1,1'b1,3'd0,3'd0,2'd0,1'b0, 0, 0}; // resume
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1, 3'd3,1'b0,3'd0,3'd1,2'd0,1'b0, 0, 0};
      tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd3,1'b0,3'd0,3'd1,2'd0,1'b0, 0, 0};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 3'd3,1'b0,3'd0,3'd1,2'd0,1'b0, 0, 0}; // goal in POINT
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd1,1'b1,3'd0,3'd1,2'd0,1'b0, 1, 0}; // serve
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 3'd3,1'b0,3'd1,3'd1,2'd0,1'b1, 1, 0};
      tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd3,1'b0,3'd1,3'd1,2'd0,1'b1, 1, 0};
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd1,1'b1,3'd1,3'd1,2'd0,1'b1, 2, 0};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1, 3'd3,1'b0,3'd2,3'd1,2'd0,1'b1, 2, 0}; // both goals
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd3,1'b0,3'd2,3'd1,2'd0,1'b1, 2, 0};
      tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd1,1'b1,3'd2,3'd1,2'd0,1'b1, 3, 0};
      tbl[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1, 3'd4,1'b0,3'd3,3'd1,2'd1,1'b1, 3, 0}; // win + entry tick
      tbl[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd4,1'b0,3'd3,3'd1,2'd1,1'b1, 3, 0};
      tbl[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd4,1'b0,3'd3,3'd1,2'd1,1'b1, 3, 0};
      tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1, 3'd0,1'b0,3'd0,3'd0,2'd0,1'b1, 3, 1}; // auto-return
      tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 3'd0,1'b0,3'd0,3'd0,2'd0,1'b1, 3, 1}; // goal in IDLE
      tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,10, 3'd1,1'b1,3'd0,3'd0,2'd0,1'b1, 3, 1};

      set_idle();
      reset = 1'b1;
      repeat (3) tick();
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      chk("reset serve", int'(serve), 0);
      chk("reset game_reset", int'(game_reset), 0);
      reset = 1'b0;
      repeat (12) tick();

      // Start: run rises 2+4+1+1 cycles after the key falls.
      key0 = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 7) chk("start state@7", int'(state), 0);
         if (i == 8) begin
            chk("start state@8", int'(state), 1);
            chk("start run@8", int'(run), 1);
         end
      end
      set_idle();
      repeat (10) tick();
      chk("start game_reset count", n_gr, 0);

      for (int r = 0; r < NV; r++) begin
         key0 = ~tbl[r].p0; key1 = ~tbl[r].p1;
         frame_tick = tbl[r].tk; goal_p1 = tbl[r].g1; goal_p2 = tbl[r].g2;
         repeat (tbl[r].cyc) tick();
         set_idle();
         tick();
         chk_all($sformatf("row%0d", r), int'(tbl[r].st), int'(tbl[r].run), int'(tbl[r].s1),
                 int'(tbl[r].s2), int'(tbl[r].win), int'(tbl[r].side));
         chk($sformatf("row%0d serves", r), n_serve, tbl[r].ns);
         chk($sformatf("row%0d game_resets", r), n_gr, tbl[r].ng);
         if (tbl[r].p0 || tbl[r].p1) repeat (8) tick();
      end

      // Goal in the same cycle as k0_ev: goal taken, key dropped.
      base_s = n_serve;
      key0 = 1'b0;
      repeat (7) tick();
      goal_p2 = 1'b1;
      tick();
      goal_p2 = 1'b0;
      chk_all("goal+key", 3, 0, 0, 1, 0, 0);
      repeat (2) tick();
      set_idle();
      repeat (10) tick();
      chk("goal+key later state", int'(state), 3);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      chk("serve pulse", int'(serve), 1);
      chk("serve state", int'(state), 1);
      chk("serve run", int'(run), 1);
      tick();
      chk("serve width", int'(serve), 0);
      chk("serve count", n_serve, base_s + 1);

      // key1 override in POINT with score_2=2, colliding with the serve tick.
      goal_p2 = 1'b1; tick(); goal_p2 = 1'b0;
      chk("pre-override score_2", int'(score_2), 2);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      base_s = n_serve;
      base_g = n_gr;
      key1 = 1'b0;
      repeat (7) tick();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      chk_all("override", 0, 0, 0, 0, 0, 0);
      chk("override game_reset", int'(game_reset), 1);
      repeat (2) tick();
      set_idle();
      repeat (10) tick();
      chk("override serves", n_serve, base_s);
      chk("override game_resets", n_gr, base_g + 1);
      chk("serve/game_reset overlap", n_both, 0);

      // Asynchronous reset in the middle of POINT.
      key0 = 1'b0; repeat (10) tick(); set_idle(); repeat (10) tick();
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("pre-reset state", int'(state), 3);
      reset = 1'b1;
      #2;
      chk_all("async reset", 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
